key_switch_bank: RTL

KEY_SWITCH_BANK -- requirements
Module: key_switch_bank

---
 rtl/key_switch_bank_if.sv | 24 ++
 rtl/key_switch_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/key_switch_bank_if.sv
// Key/switch bank signal bundle: raw keys and clear in, debounced levels and event pulses out.
// release/repeat are SV keywords, hence the _pulse suffix on those two outputs.
interface key_switch_bank_if #(
  parameter int unsigned N = 4
) ();
  logic [N-1:0] key;
  logic         clr;
  logic [N-1:0] level;
  logic [N-1:0] switch;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;
  logic [N-1:0] repeat_pulse;

  modport master (
    output key, clr,
    input  level, switch, press, release_pulse, long_press, repeat_pulse
  );

  modport slave (
    input  key, clr,
    output level, switch, press, release_pulse, long_press, repeat_pulse
  );
endinterface

// File: rtl/key_switch_bank.sv
// Bank of N independent debounced keys with toggle state, press/release edges,
// long-press detection and auto-repeat.
module key_switch_bank #(
  parameter int unsigned  N        = 4,
  parameter int unsigned  DEBOUNCE = 16,
  parameter int unsigned  LONG     = 1000,
  parameter int unsigned  REPEAT   = 200,
  parameter logic [N-1:0] INIT     = '0
) (
  input logic              clk,
  input logic              rstn,
  key_switch_bank_if.slave bus
);
  localparam int unsigned DbW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned HoldW = $clog2(LONG + 1);
  localparam int unsigned RepW  = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG);
  localparam logic [RepW-1:0]  RepLast  = RepW'((REPEAT > 0) ? REPEAT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StHold, StLongHeld} hold_st_e;

  logic [N-1:0]     sync1_q, sync2_q;
  logic [N-1:0]     pressed, rise, fall;
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     switch_q, switch_d;
  logic [N-1:0]     press_q, release_q;
  logic [N-1:0]     long_q, long_d;
  logic [N-1:0]     rpt_q, rpt_d;
  logic [DbW-1:0]   db_cnt_q   [N];
  logic [DbW-1:0]   db_cnt_d   [N];
  logic [HoldW-1:0] hold_cnt_q [N];
  logic [HoldW-1:0] hold_cnt_d [N];
  logic [RepW-1:0]  rep_cnt_q  [N];
  logic [RepW-1:0]  rep_cnt_d  [N];
  hold_st_e         st_q       [N];
  hold_st_e         st_d       [N];

  // Synchronizer idles at 1 so a key held through reset looks like a fresh press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.key;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N; i++) begin
      db_cnt_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = pressed[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = level_q & ~level_d;

  // Toggle follows the registered press pulse so clr in that same cycle wins.
  assign switch_d = bus.clr ? INIT : (switch_q ^ press_q);

  always_comb begin
    long_d = '0;
    rpt_d  = '0;
    for (int i = 0; i < N; i++) begin
      st_d[i]       = st_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rep_cnt_d[i]  = rep_cnt_q[i];
      if (fall[i]) begin
        st_d[i]       = StIdle;
        hold_cnt_d[i] = '0;
        rep_cnt_d[i]  = '0;
      end else begin
        unique case (st_q[i])
          StIdle: begin
            if (rise[i]) begin
              st_d[i]       = StHold;
              hold_cnt_d[i] = HoldW'(1);
            end
          end
          StHold: begin
            if (hold_cnt_q[i] == HoldLast) begin
              long_d[i]     = 1'b1;
              st_d[i]       = StLongHeld;
              hold_cnt_d[i] = '0;
              rep_cnt_d[i]  = '0;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
            end
          end
          StLongHeld: begin
            if (REPEAT > 0) begin
              // Counter is about to reach REPEAT: pulse and restart from 0.
              if (rep_cnt_q[i] == RepLast) begin
                rpt_d[i]     = 1'b1;
                rep_cnt_d[i] = '0;
              end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
              end
            end else if (rep_cnt_q[i] != '1) begin
              rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
            end
          end
          default: begin
            st_d[i] = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q   <= '0;
      switch_q  <= INIT;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      rpt_q     <= '0;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
        rep_cnt_q[i]  <= '0;
        st_q[i]       <= StIdle;
      end
    end else begin
      level_q   <= level_d;
      switch_q  <= switch_d;
      press_q   <= rise;
      release_q <= fall;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rep_cnt_q[i]  <= rep_cnt_d[i];
        st_q[i]       <= st_d[i];
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.switch        = switch_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_press    = long_q;
  assign bus.repeat_pulse  = rpt_q;

endmodule
